// File: rtl/note_recorder.sv
// note_recorder: records held note keys into a beat buffer and loops them back.
// One buffer slot per clk22 edge; tones go to the note generator.
module note_recorder #(
  parameter int MAX_BEATS = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              clk22,
  input  logic              rst,
  input  logic              rec_req,
  input  logic              play_req,
  input  logic              stop_req,
  input  logic [7:0]        note_keys,
  output logic [31:0]       toneL,
  output logic [31:0]       toneR,
  output logic              en_out,
  output logic [ADDR_W-1:0] beat_num,
  output logic [ADDR_W:0]   rec_len,
  output logic              full,
  output logic [1:0]        mode
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  localparam logic [31:0] SILENT = 32'd50_000_000;
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(MAX_BEATS - 1);
  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(MAX_BEATS);
  localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W + 1)'(1);

  state_t state;

  logic       rec_d;
  logic       play_d;
  logic       armed;
  logic       rec_edge;
  logic       play_edge;
  logic       mem_we;
  logic       last_play;
  logic [3:0] key_slot;
  logic [3:0] rd_slot;

  logic [3:0] mem [MAX_BEATS];

  // Slot code: {valid, idx}, idx is the lowest held key.
  function automatic logic [3:0] encode(input logic [7:0] keys);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (keys[i]) s = {1'b1, 3'(i)};
    end
    return s;
  endfunction

  function automatic logic [31:0] tone_l(input logic [3:0] slot);
    logic [31:0] t;
    case (slot[2:0])
      3'd0:    t = 32'd262;
      3'd1:    t = 32'd294;
      3'd2:    t = 32'd330;
      3'd3:    t = 32'd349;
      3'd4:    t = 32'd392;
      3'd5:    t = 32'd440;
      3'd6:    t = 32'd494;
      default: t = 32'd523;
    endcase
    return slot[3] ? t : SILENT;
  endfunction

  // Right channel sits one octave below the left.
  function automatic logic [31:0] tone_r(input logic [3:0] slot);
    return slot[3] ? (tone_l(slot) >> 1) : SILENT;
  endfunction

  assign mode      = state;
  assign rec_edge  = armed & rec_req & ~rec_d;
  assign play_edge = armed & play_req & ~play_d;
  assign key_slot  = encode(note_keys);
  assign rd_slot   = mem[beat_num];
  assign last_play = ({1'b0, beat_num} == (rec_len - ONE_LEN));
  assign mem_we    = (state == RECORD) & ~stop_req;

  // Delayed request copies; armed masks requests already high at reset release.
  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      rec_d  <= 1'b0;
      play_d <= 1'b0;
      armed  <= 1'b0;
    end else begin
      rec_d  <= rec_req;
      play_d <= play_req;
      armed  <= 1'b1;
    end
  end

  // Beat buffer; contents survive reset and stop.
  always_ff @(posedge clk22) begin
    if (mem_we) mem[beat_num] <= key_slot;
  end

  // Mode FSM with pointers, length, and registered tone/enable outputs.
  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_num <= '0;
      rec_len  <= '0;
      full     <= 1'b0;
      en_out   <= 1'b0;
      toneL    <= SILENT;
      toneR    <= SILENT;
    end else begin
      toneL  <= SILENT;
      toneR  <= SILENT;
      en_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (stop_req) begin
            state <= IDLE;
          end else if (rec_edge) begin
            state    <= RECORD;
            beat_num <= '0;
            rec_len  <= '0;
            full     <= 1'b0;
            en_out   <= 1'b1;
          end else if (play_edge && rec_len != '0) begin
            state    <= PLAY;
            beat_num <= '0;
            en_out   <= 1'b1;
          end
        end
        RECORD: begin
          if (stop_req) begin
            state    <= IDLE;
            rec_len  <= {1'b0, beat_num};
            beat_num <= '0;
          end else if (beat_num == LAST_BEAT) begin
            state    <= IDLE;
            full     <= 1'b1;
            rec_len  <= FULL_LEN;
            beat_num <= '0;
          end else begin
            beat_num <= beat_num + 1'b1;
            en_out   <= 1'b1;
            toneL    <= tone_l(key_slot);
            toneR    <= tone_r(key_slot);
          end
        end
        PLAY: begin
          if (stop_req) begin
            state    <= IDLE;
            beat_num <= '0;
          end else if (rec_edge) begin
            state    <= RECORD;
            beat_num <= '0;
            rec_len  <= '0;
            full     <= 1'b0;
            en_out   <= 1'b1;
          end else begin
            en_out <= 1'b1;
            toneL  <= tone_l(rd_slot);
            toneR  <= tone_r(rd_slot);
            if (play_edge || last_play) beat_num <= '0;
            else beat_num <= beat_num + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          beat_num <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Scoreboard bench for note_recorder with a 16-beat buffer.
// Stimulus queues expected outputs; a monitor pops them after each edge.
module tb_note_recorder;

  localparam logic [31:0] SIL = 32'd50_000_000;

  logic        clk22 = 1'b0;
  logic        rst;
  logic        rec_req;
  logic        play_req;
  logic        stop_req;
  logic [7:0]  note_keys;
  logic [31:0] toneL;
  logic [31:0] toneR;
  logic        en_out;
  logic [3:0]  beat_num;
  logic [4:0]  rec_len;
  logic        full;
  logic [1:0]  mode;

  typedef struct {
    string       nm;
    logic [1:0]  m;
    logic [3:0]  b;
    logic [4:0]  l;
    logic        f;
    logic [31:0] tl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int tab[8] = '{262, 294, 330, 349, 392, 440, 494, 523};
  int pat[5] = '{330, 330, 330, 50_000_000, 50_000_000};

  note_recorder #(.MAX_BEATS(16), .ADDR_W(4)) dut (
    .clk22    (clk22),
    .rst      (rst),
    .rec_req  (rec_req),
    .play_req (play_req),
    .stop_req (stop_req),
    .note_keys(note_keys),
    .toneL    (toneL),
    .toneR    (toneR),
    .en_out   (en_out),
    .beat_num (beat_num),
    .rec_len  (rec_len),
    .full     (full),
    .mode     (mode)
  );

  always #5 clk22 = ~clk22;

  task automatic cmp(input exp_t e);
    logic [31:0] tr;
    logic        en;
    tr = (e.tl == SIL) ? SIL : (e.tl >> 1);
    en = (e.m != 2'd0);
    checks++;
    if (mode !== e.m || beat_num !== e.b || rec_len !== e.l ||
        full !== e.f || en_out !== en || toneL !== e.tl || toneR !== tr) begin
      errors++;
      $display("FAIL %s: got mode=%0d beat=%0d len=%0d full=%0d en=%0d L=%0d R=%0d, want mode=%0d beat=%0d len=%0d full=%0d en=%0d L=%0d R=%0d",
               e.nm, mode, beat_num, rec_len, full, en_out, toneL, toneR,
               e.m, e.b, e.l, e.f, en, e.tl, tr);
    end
  endtask

  task automatic step(input logic r, input logic p, input logic s,
                      input logic [7:0] k, input string nm,
                      input logic [1:0] m, input int b, input int l,
                      input logic f, input logic [31:0] tl);
    exp_t e;
    @(negedge clk22);
    rec_req   = r;
    play_req  = p;
    stop_req  = s;
    note_keys = k;
    e.nm = nm;
    e.m  = m;
    e.b  = 4'(b);
    e.l  = 5'(l);
    e.f  = f;
    e.tl = tl;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk22);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e);
      end
    end
  end

  initial begin
    exp_t e;
    rst       = 1'b1;
    rec_req   = 1'b1;
    play_req  = 1'b0;
    stop_req  = 1'b0;
    note_keys = 8'h00;
    repeat (2) @(negedge clk22);
    e = '{nm: "reset", m: 2'd0, b: 4'd0, l: 5'd0, f: 1'b0, tl: SIL};
    cmp(e);
    rst = 1'b0;

    step(1, 0, 0, 8'h00, "no_edge_at_release", 0, 0, 0, 0, SIL);
    step(0, 1, 0, 8'h00, "play_empty", 0, 0, 0, 0, SIL);
    step(0, 0, 0, 8'h00, "idle_pre", 0, 0, 0, 0, SIL);

    step(1, 0, 0, 8'h04, "rec_start", 1, 0, 0, 0, SIL);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 8'h04, "rec_note", 1, i + 1, 0, 0, 32'd330);
    for (int i = 0; i < 2; i++)
      step(1, 0, 0, 8'h00, "rec_rest", 1, i + 4, 0, 0, SIL);
    step(0, 0, 1, 8'h00, "rec_stop", 0, 0, 5, 0, SIL);
    step(0, 0, 0, 8'h00, "idle", 0, 0, 5, 0, SIL);
    step(0, 1, 0, 8'h00, "play_start", 2, 0, 5, 0, SIL);
    for (int j = 0; j < 7; j++)
      step(0, 1, 0, 8'h00, "play_loop", 2, (j + 1) % 5, 5, 0,
           32'(pat[j % 5]));
    step(1, 0, 1, 8'h00, "stop_rec_same", 0, 0, 5, 0, SIL);
    step(0, 0, 0, 8'h00, "idle2", 0, 0, 5, 0, SIL);

    step(1, 0, 0, 8'h81, "rec2_start", 1, 0, 0, 0, SIL);
    step(1, 0, 0, 8'h81, "rec2_note", 1, 1, 0, 0, 32'd262);
    step(1, 0, 0, 8'h81, "rec2_note", 1, 2, 0, 0, 32'd262);
    step(0, 0, 1, 8'h00, "rec2_stop", 0, 0, 2, 0, SIL);
    step(0, 1, 0, 8'h00, "play2_start", 2, 0, 2, 0, SIL);
    step(0, 1, 0, 8'h00, "play2_b0", 2, 1, 2, 0, 32'd262);
    step(0, 1, 0, 8'h00, "play2_wrap", 2, 0, 2, 0, 32'd262);
    step(0, 0, 0, 8'h00, "play2_low", 2, 1, 2, 0, 32'd262);
    step(0, 1, 0, 8'h00, "play2_restart", 2, 0, 2, 0, 32'd262);
    step(0, 0, 1, 8'h00, "play2_stop", 0, 0, 2, 0, SIL);

    step(1, 0, 0, 8'h00, "rec3_start", 1, 0, 0, 0, SIL);
    for (int i = 0; i < 16; i++) begin
      if (i < 15)
        step(i == 5, 0, 0, 8'(1 << (i % 8)), "rec3_fill", 1, i + 1,
             0, 0, 32'(tab[i % 8]));
      else
        step(0, 0, 0, 8'(1 << (i % 8)), "rec3_full", 0, 0, 16, 1, SIL);
    end
    step(0, 0, 0, 8'h00, "idle3", 0, 0, 16, 1, SIL);
    step(0, 1, 0, 8'h00, "play3_start", 2, 0, 16, 1, SIL);
    for (int j = 0; j < 18; j++)
      step(0, 0, 0, 8'h00, "play3_loop", 2, (j + 1) % 16, 16, 1,
           32'(tab[j % 8]));
    step(0, 0, 1, 8'h00, "play3_stop", 0, 0, 16, 1, SIL);

    step(0, 1, 0, 8'h00, "play4_start", 2, 0, 16, 1, SIL);
    step(0, 0, 0, 8'h00, "play4_run", 2, 1, 16, 1, 32'd262);
    @(posedge clk22);
    #3;
    rst = 1'b1;
    #1;
    e = '{nm: "async_reset", m: 2'd0, b: 4'd0, l: 5'd0, f: 1'b0, tl: SIL};
    cmp(e);
    @(negedge clk22);
    rst = 1'b0;
    step(0, 1, 0, 8'h00, "play_after_rst", 0, 0, 0, 0, SIL);
    step(0, 0, 0, 8'h00, "idle_after_rst", 0, 0, 0, 0, SIL);

    repeat (2) @(negedge clk22);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
